// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave bridging PS register accesses onto a single-cycle SRAM-style reg port.
// Write and read channels run as independent FSMs with fully registered outputs.
module axil_reg_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                        s_axil_arvalid,
  output logic                        s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                  s_axil_rresp,
  output logic                        s_axil_rvalid,
  input  logic                        s_axil_rready,
  output logic                        reg_wr_en,
  output logic [AXI_ADDR_WIDTH-1:0]   reg_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]   reg_wr_data,
  output logic                        reg_rd_en,
  output logic [AXI_ADDR_WIDTH-1:0]   reg_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   reg_rd_data
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int ALSB   = $clog2(STRB_W);
  localparam logic [AXI_ADDR_WIDTH-1:0] NUM_REGS_A = AXI_ADDR_WIDTH'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_COLLECT, W_EXEC, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_CAPT, R_RESP} rd_state_t;

  wr_state_t                 wr_state;
  rd_state_t                 rd_state;
  logic                      aw_held;
  logic                      w_held;
  logic                      wr_err;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      ar_hs;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_sel;
  logic [AXI_DATA_WIDTH-1:0] wr_data_sel;
  logic [STRB_W-1:0]         wr_strb_sel;
  logic [AXI_ADDR_WIDTH-1:0] wr_idx;
  logic [AXI_ADDR_WIDTH-1:0] rd_idx;
  logic                      wr_ok;
  logic                      rd_ok;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  // The completing handshake may arrive this cycle, so take the live bus value when not yet held.
  assign wr_addr_sel = aw_held ? aw_addr_q : s_axil_awaddr;
  assign wr_data_sel = w_held ? w_data_q : s_axil_wdata;
  assign wr_strb_sel = w_held ? w_strb_q : s_axil_wstrb;
  assign wr_idx      = wr_addr_sel >> ALSB;
  assign rd_idx      = s_axil_araddr >> ALSB;
  assign wr_ok       = (wr_idx < NUM_REGS_A) && (&wr_strb_sel);
  assign rd_ok       = rd_idx < NUM_REGS_A;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state       <= W_COLLECT;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      wr_err         <= 1'b0;
      aw_addr_q      <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      reg_wr_en      <= 1'b0;
      reg_wr_addr    <= '0;
      reg_wr_data    <= '0;
    end else begin
      reg_wr_en <= 1'b0;
      case (wr_state)
        W_COLLECT: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_axil_awaddr;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axil_wdata;
            w_strb_q <= s_axil_wstrb;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            reg_wr_en      <= wr_ok;
            wr_err         <= !wr_ok;
            if (wr_ok) begin
              reg_wr_addr <= wr_idx;
              reg_wr_data <= wr_data_sel;
            end
            wr_state <= W_EXEC;
          end else begin
            s_axil_awready <= !(aw_held || aw_hs);
            s_axil_wready  <= !(w_held || w_hs);
          end
        end
        W_EXEC: begin
          s_axil_bvalid <= 1'b1;
          s_axil_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
          wr_state      <= W_RESP;
        end
        W_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid  <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            s_axil_awready <= 1'b1;
            s_axil_wready  <= 1'b1;
            wr_state       <= W_COLLECT;
          end
        end
        default: wr_state <= W_COLLECT;
      endcase
    end
  end

  // Out-of-range reads skip the reg port entirely and answer SLVERR one cycle after AR.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state       <= R_IDLE;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= RESP_OKAY;
      reg_rd_en      <= 1'b0;
      reg_rd_addr    <= '0;
    end else begin
      reg_rd_en <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_axil_arready <= 1'b0;
            if (rd_ok) begin
              reg_rd_en   <= 1'b1;
              reg_rd_addr <= rd_idx;
              rd_state    <= R_ISSUE;
            end else begin
              s_axil_rvalid <= 1'b1;
              s_axil_rdata  <= '0;
              s_axil_rresp  <= RESP_SLVERR;
              rd_state      <= R_RESP;
            end
          end else begin
            s_axil_arready <= 1'b1;
          end
        end
        R_ISSUE: rd_state <= R_CAPT;
        R_CAPT: begin
          s_axil_rdata  <= reg_rd_data;
          s_axil_rresp  <= RESP_OKAY;
          s_axil_rvalid <= 1'b1;
          rd_state      <= R_RESP;
        end
        R_RESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid  <= 1'b0;
            s_axil_arready <= 1'b1;
            rd_state       <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Scoreboard bench for axil_reg_bridge: expectations are queued when stimulus is driven
// and popped when the reg port strobes or the B/R channels respond.
module tb_axil_reg_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, reg_rd_data = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, reg_wr_en, reg_rd_en;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, reg_wr_addr, reg_wr_data, reg_rd_addr;

  int compared = 0;
  int mismatched = 0;
  int wr_en_count = 0;
  int rd_en_count = 0;

  typedef struct {logic [31:0] idx; logic [31:0] data;} strobe_t;
  typedef struct {logic [31:0] data; logic [1:0] resp;} rd_exp_t;
  strobe_t    strobe_q[$];
  logic [1:0] bresp_q[$];
  rd_exp_t    rd_q[$];

  always #5 clk = ~clk;

  axil_reg_bridge #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .clk(clk), .rstn(rstn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data)
  );

  // Register-file model: one-clock read latency, contents derived from the word index.
  function automatic logic [31:0] rd_model(input logic [31:0] idx);
    return 32'h50 + idx;
  endfunction

  always @(posedge clk) begin
    if (reg_rd_en) reg_rd_data <= rd_model(reg_rd_addr);
    if (reg_wr_en) wr_en_count <= wr_en_count + 1;
    if (reg_rd_en) rd_en_count <= rd_en_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({awready, wready, arready, bvalid, rvalid, reg_wr_en, reg_rd_en} !== 7'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {awready, wready, arready, bvalid, rvalid, reg_wr_en, reg_rd_en});
    end
    compared++;
    if ({bresp, rresp, rdata, reg_wr_addr, reg_wr_data, reg_rd_addr} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got bresp=%h rresp=%h rdata=%h waddr=%h wdata=%h raddr=%h expected all 0",
               bresp, rresp, rdata, reg_wr_addr, reg_wr_data, reg_rd_addr);
    end
    rstn = 1'b1;
    tick();
    compared++;
    if ({awready, wready, arready} !== 3'b111) begin
      mismatched++;
      $display("[TB] FAIL reset_release_ready: got %b expected 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_same_cycle();
    strobe_t exp;
    strobe_q.push_back('{idx: 32'd2, data: 32'hDEADBEEF});
    bresp_q.push_back(2'b00);
    drive_write(32'h08, 32'hDEADBEEF, 4'hF);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    exp = strobe_q.pop_front();
    compared++;
    if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, exp.idx, exp.data}) begin
      mismatched++;
      $display("[TB] FAIL t1_strobe: got en=%b addr=%h data=%h expected en=1 addr=%h data=%h",
               reg_wr_en, reg_wr_addr, reg_wr_data, exp.idx, exp.data);
    end
    compared++;
    if ({awready, wready, bvalid} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL t1_exec_ctrl: got aw/w/bvalid=%b expected 000", {awready, wready, bvalid});
    end
    tick();
    compared++;
    if ({reg_wr_en, bvalid, bresp} !== {1'b0, 1'b1, bresp_q.pop_front()}) begin
      mismatched++;
      $display("[TB] FAIL t1_bresp: got en=%b bvalid=%b bresp=%h expected en=0 bvalid=1 bresp=0",
               reg_wr_en, bvalid, bresp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    compared++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      mismatched++;
      $display("[TB] FAIL t1_after_b: got bvalid/aw/w=%b expected 011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_write_w_first();
    strobe_t exp;
    strobe_q.push_back('{idx: 32'd3, data: 32'h12345678});
    bresp_q.push_back(2'b00);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      compared++;
      if ({wready, awready, reg_wr_en} !== 3'b010) begin
        mismatched++;
        $display("[TB] FAIL t2_wait_N+%0d: got wready/awready/en=%b expected 010", k, {wready, awready, reg_wr_en});
      end
      if (k != 3) tick();
    end
    awaddr = 32'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    exp = strobe_q.pop_front();
    compared++;
    if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, exp.idx, exp.data}) begin
      mismatched++;
      $display("[TB] FAIL t2_strobe: got en=%b addr=%h data=%h expected en=1 addr=%h data=%h",
               reg_wr_en, reg_wr_addr, reg_wr_data, exp.idx, exp.data);
    end
    tick();
    compared++;
    if ({bvalid, bresp} !== {1'b1, bresp_q.pop_front()}) begin
      mismatched++;
      $display("[TB] FAIL t2_bresp: got bvalid=%b bresp=%h expected bvalid=1 bresp=0", bvalid, bresp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_read();
    rd_exp_t exp;
    rd_q.push_back('{data: 32'h55, resp: 2'b00});
    araddr = 32'h14; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    compared++;
    if ({reg_rd_en, reg_rd_addr, rvalid, arready} !== {1'b1, 32'd5, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL t3_issue: got en=%b addr=%h rvalid=%b arready=%b expected en=1 addr=5 rvalid=0 arready=0",
               reg_rd_en, reg_rd_addr, rvalid, arready);
    end
    tick();
    compared++;
    if ({reg_rd_en, rvalid} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL t3_capt: got en/rvalid=%b expected 00", {reg_rd_en, rvalid});
    end
    tick();
    exp = rd_q.pop_front();
    compared++;
    if ({rvalid, rdata, rresp} !== {1'b1, exp.data, exp.resp}) begin
      mismatched++;
      $display("[TB] FAIL t3_rdata: got rvalid=%b rdata=%h rresp=%h expected rvalid=1 rdata=%h rresp=%h",
               rvalid, rdata, rresp, exp.data, exp.resp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    compared++;
    if ({rvalid, arready} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL t3_after_r: got rvalid/arready=%b expected 01", {rvalid, arready});
    end
  endtask

  task automatic test_errors();
    rd_exp_t exp;
    int      cnt0;
    cnt0 = wr_en_count;
    bresp_q.push_back(2'b10);
    drive_write(32'h20, 32'h11111111, 4'hF);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    compared++;
    if (reg_wr_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL t4_range_no_strobe: got %b expected 0", reg_wr_en);
    end
    tick();
    compared++;
    if ({bvalid, bresp} !== {1'b1, bresp_q.pop_front()}) begin
      mismatched++;
      $display("[TB] FAIL t4_range_bresp: got bvalid=%b bresp=%h expected bvalid=1 bresp=2", bvalid, bresp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    bresp_q.push_back(2'b10);
    drive_write(32'h04, 32'h22222222, 4'h3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    compared++;
    if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b0, 32'd3, 32'h12345678}) begin
      mismatched++;
      $display("[TB] FAIL t4_strb_no_strobe: got en=%b addr=%h data=%h expected en=0 addr=3 data=12345678",
               reg_wr_en, reg_wr_addr, reg_wr_data);
    end
    tick();
    compared++;
    if ({bvalid, bresp} !== {1'b1, bresp_q.pop_front()}) begin
      mismatched++;
      $display("[TB] FAIL t4_strb_bresp: got bvalid=%b bresp=%h expected bvalid=1 bresp=2", bvalid, bresp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    rd_q.push_back('{data: 32'h0, resp: 2'b10});
    araddr = 32'h40; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    exp = rd_q.pop_front();
    compared++;
    if ({rvalid, rdata, rresp, reg_rd_en} !== {1'b1, exp.data, exp.resp, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL t4_range_read: got rvalid=%b rdata=%h rresp=%h en=%b expected rvalid=1 rdata=0 rresp=2 en=0",
               rvalid, rdata, rresp, reg_rd_en);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    compared++;
    if (wr_en_count !== cnt0) begin
      mismatched++;
      $display("[TB] FAIL t4_strobe_count: got %0d expected %0d", wr_en_count, cnt0);
    end
  endtask

  task automatic test_backpressure();
    strobe_t exp;
    rd_exp_t rexp;
    logic [1:0] bexp;
    int wc0, rc0;
    strobe_q.push_back('{idx: 32'd1, data: 32'hA5A50001});
    bresp_q.push_back(2'b00);
    rd_q.push_back('{data: 32'h57, resp: 2'b00});
    drive_write(32'h04, 32'hA5A50001, 4'hF);
    araddr = 32'h1C; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp = strobe_q.pop_front();
    compared++;
    if ({reg_wr_en, reg_wr_addr, reg_rd_en, reg_rd_addr} !== {1'b1, exp.idx, 1'b1, 32'd7}) begin
      mismatched++;
      $display("[TB] FAIL t5_dual_strobe: got wen=%b waddr=%h ren=%b raddr=%h expected wen=1 waddr=%h ren=1 raddr=7",
               reg_wr_en, reg_wr_addr, reg_rd_en, reg_rd_addr, exp.idx);
    end
    tick();
    tick();
    bexp = bresp_q.pop_front();
    rexp = rd_q.pop_front();
    wc0 = wr_en_count;
    rc0 = rd_en_count;
    for (int k = 0; k < 10; k++) begin
      awvalid = 1'($urandom_range(1)); wvalid = 1'($urandom_range(1)); arvalid = 1'($urandom_range(1));
      awaddr = 32'($urandom_range(7)) << 2; araddr = 32'($urandom_range(7)) << 2;
      wdata = $urandom; wstrb = 4'hF;
      compared++;
      if ({bvalid, bresp, rvalid, rdata, rresp} !== {1'b1, bexp, 1'b1, rexp.data, rexp.resp}) begin
        mismatched++;
        $display("[TB] FAIL t5_hold_%0d: got bvalid=%b bresp=%h rvalid=%b rdata=%h rresp=%h expected 1 %h 1 %h %h",
                 k, bvalid, bresp, rvalid, rdata, rresp, bexp, rexp.data, rexp.resp);
      end
      compared++;
      if ({awready, wready, arready} !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL t5_no_accept_%0d: got aw/w/ar ready=%b expected 000", k, {awready, wready, arready});
      end
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    compared++;
    if ({wr_en_count, rd_en_count} !== {wc0, rc0}) begin
      mismatched++;
      $display("[TB] FAIL t5_strobe_count: got wr=%0d rd=%0d expected wr=%0d rd=%0d", wr_en_count, rd_en_count, wc0, rc0);
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    compared++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      mismatched++;
      $display("[TB] FAIL t5_release: got b/r valid aw/w/ar ready=%b expected 00111",
               {bvalid, rvalid, awready, wready, arready});
    end
  endtask

  task automatic test_reset_midflight();
    strobe_t exp;
    rd_exp_t rexp;
    araddr = 32'h08; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    drive_write(32'h10, 32'hBAD0BAD0, 4'hF);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    compared++;
    if ({reg_wr_en, reg_rd_en, rvalid} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL t6_pre_state: got wen/ren/rvalid=%b expected 100", {reg_wr_en, reg_rd_en, rvalid});
    end
    rstn = 1'b0;
    #1;
    compared++;
    if ({reg_wr_en, reg_rd_en, bvalid, rvalid, awready, wready, arready} !== 7'b0) begin
      mismatched++;
      $display("[TB] FAIL t6_async_ctrl: got %b expected 0000000",
               {reg_wr_en, reg_rd_en, bvalid, rvalid, awready, wready, arready});
    end
    compared++;
    if ({reg_wr_addr, reg_wr_data, rdata} !== '0) begin
      mismatched++;
      $display("[TB] FAIL t6_async_data: got waddr=%h wdata=%h rdata=%h expected 0", reg_wr_addr, reg_wr_data, rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    compared++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      mismatched++;
      $display("[TB] FAIL t6_release: got aw/w/ar ready b/r valid=%b expected 11100",
               {awready, wready, arready, bvalid, rvalid});
    end
    strobe_q.push_back('{idx: 32'd6, data: 32'hCAFEF00D});
    bresp_q.push_back(2'b00);
    rd_q.push_back('{data: 32'h52, resp: 2'b00});
    drive_write(32'h18, 32'hCAFEF00D, 4'hF);
    araddr = 32'h08; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp = strobe_q.pop_front();
    compared++;
    if ({reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr} !== {1'b1, exp.idx, exp.data, 1'b1, 32'd2}) begin
      mismatched++;
      $display("[TB] FAIL t6_fresh_strobe: got wen=%b waddr=%h wdata=%h ren=%b raddr=%h expected 1 %h %h 1 2",
               reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr, exp.idx, exp.data);
    end
    tick();
    compared++;
    if ({bvalid, bresp} !== {1'b1, bresp_q.pop_front()}) begin
      mismatched++;
      $display("[TB] FAIL t6_fresh_bresp: got bvalid=%b bresp=%h expected bvalid=1 bresp=0", bvalid, bresp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    rexp = rd_q.pop_front();
    compared++;
    if ({bvalid, rvalid, rdata, rresp} !== {1'b0, 1'b1, rexp.data, rexp.resp}) begin
      mismatched++;
      $display("[TB] FAIL t6_fresh_read: got bvalid=%b rvalid=%b rdata=%h rresp=%h expected 0 1 %h %h",
               bvalid, rvalid, rdata, rresp, rexp.data, rexp.resp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    compared++;
    if (strobe_q.size() + bresp_q.size() + rd_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0",
               strobe_q.size() + bresp_q.size() + rd_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write_same_cycle();
    test_write_w_first();
    test_read();
    test_errors();
    test_backpressure();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
